// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide unit: iterative shift-add multiply and restoring divide,
// one iteration per cycle, with a sign-fix cycle before the HI/LO write.
module hilo_muldiv_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int         W    = DATA_WIDTH;
  localparam logic [5:0] LAST = 6'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           done_q, done_d, dbz_q, dbz_d;
  logic           is_div_q, is_div_d;
  logic           neg_q_q, neg_q_d;   // product / quotient sign
  logic           neg_r_q, neg_r_d;   // remainder sign
  logic [W-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [W-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;

  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] prod, prod_fix;

  // op[0] marks the signed variants of both multiply and divide
  assign mag_a = (op[0] && src_a[W-1]) ? -src_a : src_a;
  assign mag_b = (op[0] && src_b[W-1]) ? -src_b : src_b;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  // Only consumed when div_ge holds, where the difference is below the divisor
  assign div_diff  = div_shift[W-1:0] - opnd_q;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q_q ? -prod : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            if (op[1] && src_b == '0) begin
              hi_d   = src_a;
              lo_d   = '1;
              done_d = 1'b1;
              dbz_d  = 1'b1;
            end else begin
              state_d  = CALC;
              cnt_d    = '0;
              is_div_d = op[1];
              neg_q_d  = op[0] & (src_a[W-1] ^ src_b[W-1]);
              neg_r_d  = op[0] & src_a[W-1];
              opnd_d   = op[1] ? mag_b : mag_a;
              acc_hi_d = '0;
              acc_lo_d = op[1] ? mag_a : mag_b;
            end
          end else if (!op[1]) begin
            if (op[0]) lo_d = src_a;
            else       hi_d = src_a;
            done_d = 1'b1;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff : div_shift[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], div_ge};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[W-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_q_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
